// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: datapath width
// and FSM state encoding.
package fetch_ctrl_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_JUMP = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_counter.sv
// Wrapping count of instructions handed to the decoder.
module fetch_counter
    import fetch_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: reads memory at the PC, presents the word to
// the decoder, and steers the external PC register via increment/latch pulses.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_pc_value,
    output logic             o_pc_latch,
    output logic             o_pc_inc,
    output logic [WIDTH-1:0] o_pc_data,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic [WIDTH-1:0] o_instr,
    output logic             o_instr_valid,
    input  logic             i_instr_ready,
    input  logic             i_jmp_valid,
    input  logic [WIDTH-1:0] i_jmp_addr,
    output logic             o_jmp_ready,
    output logic [WIDTH-1:0] o_fetch_count,
    output logic [1:0]       o_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a jump and an instruction hand-off in the same HOLD cycle
    // resolve in favour of the jump, and the instruction is dropped.

    state_t           r_state;
    logic             r_pc_latch;
    logic             r_pc_inc;
    logic [WIDTH-1:0] r_pc_data;
    logic             r_mem_req;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_instr;
    logic             r_instr_valid;
    logic             r_jmp_ready;

    state_t           w_state_nx;
    logic             w_jmp_acc;
    logic             w_capture;
    logic             w_count_inc;
    logic             w_take_jump;
    logic [WIDTH-1:0] w_next_pc;

    // A pulse issued this cycle lands in the PC register on the same edge, so
    // the address for the next request is what the PC is about to become.
    always_comb begin
        w_next_pc = i_pc_value;
        if (r_pc_latch) begin
            w_next_pc = r_pc_data;
        end else if (r_pc_inc) begin
            w_next_pc = i_pc_value + WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_capture   = 1'b0;
        w_count_inc = 1'b0;
        w_take_jump = 1'b0;
        w_jmp_acc   = i_jmp_valid && r_jmp_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_jmp_acc) begin
                    w_take_jump = 1'b1;
                    w_state_nx  = ST_JUMP;
                end else if (i_run) begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    w_capture  = 1'b1;
                    w_state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_jmp_acc) begin
                    w_take_jump = 1'b1;
                    w_state_nx  = ST_JUMP;
                end else if (r_instr_valid && i_instr_ready) begin
                    w_count_inc = 1'b1;
                    w_state_nx  = i_run ? ST_REQ : ST_IDLE;
                end
            end
            ST_JUMP: begin
                w_state_nx = i_run ? ST_REQ : ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pc_latch    <= 1'b0;
            r_pc_inc      <= 1'b0;
            r_pc_data     <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_jmp_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_mem_req     <= (w_state_nx == ST_REQ);
            r_instr_valid <= (w_state_nx == ST_HOLD);
            r_pc_inc      <= (w_state_nx == ST_HOLD) && (r_state == ST_REQ);
            r_pc_latch    <= (w_state_nx == ST_JUMP);
            r_jmp_ready   <= (w_state_nx == ST_IDLE) || (w_state_nx == ST_HOLD);
            if (w_state_nx == ST_REQ) begin
                r_mem_addr <= w_next_pc;
            end
            if (w_capture) begin
                r_instr <= i_mem_rdata;
            end
            if (w_take_jump) begin
                r_pc_data <= i_jmp_addr;
            end
        end
    end

    fetch_counter u_fetch_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_count_inc),
        .o_count (o_fetch_count)
    );

    assign o_state       = r_state;
    assign o_pc_latch    = r_pc_latch;
    assign o_pc_inc      = r_pc_inc;
    assign o_pc_data     = r_pc_data;
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_jmp_ready   = r_jmp_ready;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model and a memory model
// that acknowledges after a programmable number of cycles.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       run;
  logic       instr_ready;
  logic       jmp_valid;
  logic [7:0] jmp_addr;
  logic       inj_ack;

  logic       pc_latch, pc_inc, mem_req, instr_valid, jmp_ready;
  logic [7:0] pc_data, mem_addr, instr, fetch_count;
  logic [1:0] state;

  // PC register model
  logic [7:0] pc_q;
  logic       pc_set_en;
  logic [7:0] pc_set_val;

  // memory model
  logic [7:0] mem [256];
  int         ack_delay;
  int         ack_cnt;
  logic       m_ack;
  logic [7:0] m_rdata;
  logic       dut_ack;
  logic [7:0] dut_rdata;

  assign dut_ack   = m_ack | inj_ack;
  assign dut_rdata = inj_ack ? 8'hEE : m_rdata;

  fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_run         (run),
    .i_pc_value    (pc_q),
    .o_pc_latch    (pc_latch),
    .o_pc_inc      (pc_inc),
    .o_pc_data     (pc_data),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (dut_ack),
    .i_mem_rdata   (dut_rdata),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .i_jmp_valid   (jmp_valid),
    .i_jmp_addr    (jmp_addr),
    .o_jmp_ready   (jmp_ready),
    .o_fetch_count (fetch_count),
    .o_state       (state)
  );

  always @(posedge clk) begin
    if (pc_set_en)     pc_q <= pc_set_val;
    else if (pc_latch) pc_q <= pc_data;
    else if (pc_inc)   pc_q <= pc_q + 8'd1;
  end

  always @(posedge clk) begin
    m_ack <= 1'b0;
    if (mem_req && !m_ack) begin
      if (ack_cnt >= ack_delay) begin
        m_ack   <= 1'b1;
        m_rdata <= mem[mem_addr];
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  // pulse monitors
  int inc_pulses   = 0;
  int latch_pulses = 0;
  int overlap      = 0;
  always @(posedge clk) begin
    if (pc_inc)             inc_pulses   <= inc_pulses + 1;
    if (pc_latch)           latch_pulses <= latch_pulses + 1;
    if (pc_inc && pc_latch) overlap      <= overlap + 1;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks = n_checks + 1;
    n_errors = n_errors + 1;
    $display("FAIL %s timed out", tag);
  endtask

  // driver tasks
  task automatic wait_valid(input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) timeout_fail("wait_instr_valid");
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (mem_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) timeout_fail("wait_mem_req");
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set_en  = 1'b1;
    pc_set_val = v;
    @(negedge clk);
    pc_set_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
    jmp_valid = 1'b0; jmp_addr = 8'h00; inj_ack = 1'b0;
    pc_set_en = 1'b0; pc_set_val = 8'h00; pc_q = 8'h00;
    ack_delay = 2; ack_cnt = 0; m_ack = 1'b0; m_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'h12] = 8'h77;
    mem[8'h40] = 8'hC3;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_pc_inc", pc_inc, 0);
    check_eq("rst_pc_latch", pc_latch, 0);
    check_eq("rst_jmp_ready", jmp_ready, 0);
    check_eq("rst_pc_data", pc_data, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_fetch_count", fetch_count, 0);
    set_pc(8'h10);

    // sequential fetch with backpressure
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    check_eq("first_req_state", state, 2'd1);
    check_eq("first_req_mem_req", mem_req, 1);
    check_eq("first_req_addr", mem_addr, 8'h10);
    wait_valid(20);
    check_eq("seq_instr", instr, 8'hA5);
    check_eq("seq_pc_inc_first_hold", pc_inc, 1);
    check_eq("seq_jmp_ready_hold", jmp_ready, 1);
    check_eq("seq_count_before", fetch_count, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", instr_valid, 1);
      check_eq("bp_instr", instr, 8'hA5);
      check_eq("bp_mem_req", mem_req, 0);
      check_eq("bp_pc_inc", pc_inc, 0);
    end
    check_eq("bp_pc", pc_q, 8'h11);
    check_eq("bp_inc_pulses", inc_pulses, 1);
    instr_ready = 1'b1;
    @(negedge clk);
    check_eq("seq_count_after", fetch_count, 1);
    check_eq("seq_next_req", mem_req, 1);
    check_eq("seq_next_addr", mem_addr, 8'h11);
    check_eq("seq_valid_dropped", instr_valid, 0);
    check_eq("seq_jmp_ready_req", jmp_ready, 0);

    // run dropped while a request is outstanding
    run = 1'b0;
    wait_valid(20);
    check_eq("stop_instr", instr, 8'h3C);
    @(negedge clk);
    check_eq("stop_state", state, 2'd0);
    check_eq("stop_count", fetch_count, 2);
    check_eq("stop_mem_req", mem_req, 0);
    check_eq("stop_pc", pc_q, 8'h12);
    check_eq("stop_inc_pulses", inc_pulses, 2);

    // jump in the first HOLD cycle, same cycle as instr_ready
    instr_ready = 1'b0; run = 1'b1;
    wait_valid(20);
    check_eq("jmp_hold_instr", instr, 8'h77);
    check_eq("jmp_hold_pc_inc", pc_inc, 1);
    jmp_valid = 1'b1; jmp_addr = 8'h40; instr_ready = 1'b1;
    check_eq("jmp_ready_offered", jmp_ready, 1);
    @(negedge clk);
    jmp_valid = 1'b0;
    check_eq("jmp_state", state, 2'd3);
    check_eq("jmp_valid_dropped", instr_valid, 0);
    check_eq("jmp_pc_latch", pc_latch, 1);
    check_eq("jmp_pc_inc_low", pc_inc, 0);
    check_eq("jmp_pc_data", pc_data, 8'h40);
    check_eq("jmp_count_kept", fetch_count, 2);
    check_eq("jmp_ready_in_jump", jmp_ready, 0);
    @(negedge clk);
    check_eq("jmp_req_state", state, 2'd1);
    check_eq("jmp_req_addr", mem_addr, 8'h40);
    check_eq("jmp_req_mem_req", mem_req, 1);
    check_eq("jmp_pc_target", pc_q, 8'h40);
    check_eq("jmp_pc_latch_once", pc_latch, 0);
    run = 1'b0;
    wait_valid(20);
    check_eq("jmp_target_instr", instr, 8'hC3);
    @(negedge clk);
    check_eq("jmp_after_count", fetch_count, 3);
    check_eq("jmp_after_state", state, 2'd0);
    check_eq("latch_pulses", latch_pulses, 1);

    // reset in the middle of a request, then a late ack
    ack_delay = 5; run = 1'b1;
    wait_req(20);
    rst_n = 1'b0; run = 1'b0;
    #1;
    check_eq("mid_rst_state", state, 2'd0);
    check_eq("mid_rst_mem_req", mem_req, 0);
    check_eq("mid_rst_mem_addr", mem_addr, 0);
    check_eq("mid_rst_instr", instr, 0);
    check_eq("mid_rst_pc_data", pc_data, 0);
    check_eq("mid_rst_count", fetch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    check_eq("late_ack_state", state, 2'd0);
    check_eq("late_ack_instr", instr, 0);
    check_eq("late_ack_valid", instr_valid, 0);
    check_eq("late_ack_mem_req", mem_req, 0);

    // 256 fetches from 0xFF: address and count both wrap
    set_pc(8'hFF);
    ack_delay = 0; instr_ready = 1'b1; run = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wait_valid(20);
      a = 8'hFF + 8'(k);
      check_eq("wrap_instr", instr, mem[a]);
      if (k == 255) run = 1'b0;
      @(negedge clk);
    end
    check_eq("wrap_count", fetch_count, 0);
    check_eq("wrap_state", state, 2'd0);
    check_eq("wrap_pc", pc_q, 8'hFF);
    check_eq("total_inc_pulses", inc_pulses, 260);
    check_eq("inc_latch_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 WIDTH, 8, data/address width of PC, memory and instruction paths.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-low.
REQ-004 run  in  1  fetch enable; level-sensitive.
REQ-005 pc_value  in  WIDTH  current program counter register output.
REQ-006 pc_latch  out  1  one-cycle pulse; PC register loads pc_data.
REQ-007 pc_inc  out  1  one-cycle pulse; PC register increments.
REQ-008 pc_data  out  WIDTH  jump target presented to PC register.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  WIDTH  read address.
REQ-011 mem_ack  in  1  one-cycle read completion; mem_rdata valid same cycle.
REQ-012 mem_rdata  in  WIDTH  read data.
REQ-013 instr  out  WIDTH  fetched instruction.
REQ-014 instr_valid  out  1  instr valid to decoder.
REQ-015 instr_ready  in  1  decoder accepts instr.
REQ-016 jmp_valid  in  1  jump request.
REQ-017 jmp_addr  in  WIDTH  jump target.
REQ-018 jmp_ready  out  1  jump accepted when jmp_valid and jmp_ready both high.
REQ-019 fetch_count  out  WIDTH  count of instructions handed to decoder.

Function
REQ-020 FSM states IDLE, REQ, HOLD, JUMP; all outputs registered.
REQ-021 IDLE: jmp accepted -> JUMP; else run=1 -> REQ; else stay.
REQ-022 REQ: mem_req=1, mem_addr=pc_value; stay until mem_ack; on mem_ack capture mem_rdata into instr -> HOLD.
REQ-023 HOLD entry: instr_valid=1; pc_inc=1 exactly the first HOLD cycle.
REQ-024 HOLD: instr_valid && instr_ready -> fetch_count+1 (wraps 0xFF->0x00); next state REQ if run=1, else IDLE.
REQ-025 jmp_ready=1 only in IDLE and HOLD; 0 in REQ and JUMP.
REQ-026 HOLD with jmp accepted: jump wins over instr_ready; instr dropped, fetch_count unchanged, instr_valid=0 next cycle -> JUMP.
REQ-027 JUMP: pc_latch=1, pc_data=jmp_addr captured at acceptance, one cycle -> REQ if run=1 else IDLE.
REQ-028 pc_inc and pc_latch never high in same cycle; each high at most one cycle per fetch/jump.
REQ-029 Jump accepted in first HOLD cycle: pc_inc still pulses that cycle, pc_latch follows in JUMP, so jump target prevails.
REQ-030 mem_ack outside REQ ignored.
REQ-031 run deassert in REQ: outstanding request completes; FSM stops after HOLD handshake.
REQ-032 PC wrap (pc_value 0xFF) is the PC register's concern; fetch_ctrl pulses pc_inc unchanged.
REQ-033 instr holds last value except on mem_ack capture.

Reset
REQ-034 reset=0 forces immediately: state IDLE; pc_latch, pc_inc, mem_req, instr_valid, jmp_ready-internal flags 0; pc_data, mem_addr, instr, fetch_count 0x00.
REQ-035 Reset mid-REQ abandons request; a later mem_ack is ignored.
REQ-036 First fetch starts on first rising edge with reset=1 and run=1.

Structure
REQ-037 Shared package holds WIDTH default and FSM state encoding constants.
REQ-038 Single module, no sub-modules; optional counter sub-module fetch_counter for fetch_count.

Verification
REQ-039 Bench models PC register (latch/inc, 8-bit wrap) and memory with programmable ack delay.
REQ-040 Sequential fetch: pc=0x10, mem[0x10]=0xA5, ack after 2 cycles, ready=1 -> instr=0xA5, one pc_inc pulse, next mem_addr=0x11, fetch_count=1.
REQ-041 Backpressure: instr_ready low 5 cycles -> instr_valid and instr=0xA5 stable, pc_inc only once, no new mem_req.
REQ-042 Jump in HOLD: jmp_addr=0x40 with instr_ready=1 same cycle -> instr dropped, fetch_count unchanged, pc_latch pulse with pc_data=0x40, next mem_addr=0x40.
REQ-043 Wrap: pc=0xFF, 256 fetches -> mem_addr wraps to 0x00, fetch_count returns to 0x00.
REQ-044 Reset mid-REQ: reset low 1 cycle while mem_req=1, late mem_ack -> all outputs 0, state IDLE, ack ignored.
